// File: rtl/controle_tentativas_pkg.sv
// rtl/controle_tentativas_pkg.sv - shared state encodings and key constants for the attempt controller
package controle_tentativas_pkg;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ESPERA   = 2'd1,
      LIBERADO = 2'd2,
      BLOQUEIO = 2'd3
   } estado_t;

   localparam logic [3:0] TECLA_CANCELA    = 4'b1111;
   localparam logic [3:0] TECLA_MAX_DIGITO = 4'd9;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/controle_tentativas_temporizador.sv
// rtl/controle_tentativas_temporizador.sv - loadable down counter shared by the timed states
module temporizador #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         carga,
   input  logic [W-1:0] valor,
   output logic         expirou,
   output logic [W-1:0] restante
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (carga) begin
         cnt_d = valor;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Last cycle of a loaded interval, so a load of N covers exactly N cycles.
   assign expirou  = (cnt_q == W'(1));
   assign restante = cnt_q;

endmodule

// File: rtl/controle_tentativas.sv
// rtl/controle_tentativas.sv - forwards key digits to the lock machine, counts failures, enforces lockout
module controle_tentativas
   import controle_tentativas_pkg::*;
#(
   parameter  int DIGITOS         = 4,
   parameter  int MAX_TENTATIVAS  = 3,
   parameter  int ESPERA_MAX      = 8,
   parameter  int ABERTO_CICLOS   = 20,
   parameter  int BLOQUEIO_CICLOS = 50,
   localparam int TENT_W          = $clog2(MAX_TENTATIVAS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tecla_valida,
   input  logic [4:1]        tecla,
   input  logic              led_maquina,
   output logic              insere,
   output logic [4:1]        numero,
   output logic              aberto,
   output logic              bloqueado,
   output logic              aceito,
   output logic              erro,
   output logic [TENT_W-1:0] tentativas
);

   localparam int TMR_W = $clog2(max_int(max_int(ESPERA_MAX + 1, ABERTO_CICLOS), BLOQUEIO_CICLOS) + 1);
   localparam int DIG_W = $clog2(DIGITOS + 1);

   estado_t             estado_q, estado_d;
   logic [DIG_W-1:0]    dig_q, dig_d;
   logic [TENT_W-1:0]   tent_q, tent_d, tent_nova;
   logic                insere_q, insere_d;
   logic [3:0]          numero_q, numero_d;
   logic                aceito_q, aceito_d;
   logic                erro_q, erro_d;
   logic                carga;
   logic [TMR_W-1:0]    valor;
   logic                tmr_expirou;
   logic [TMR_W-1:0]    tmr_restante;

   temporizador #(.W(TMR_W)) u_temporizador (
      .clk      (clk),
      .reset    (reset),
      .carga    (carga),
      .valor    (valor),
      .expirou  (tmr_expirou),
      .restante (tmr_restante)
   );

   always_comb begin
      estado_d  = estado_q;
      dig_d     = dig_q;
      tent_d    = tent_q;
      insere_d  = 1'b0;
      numero_d  = numero_q;
      aceito_d  = 1'b0;
      erro_d    = 1'b0;
      carga     = 1'b0;
      valor     = '0;
      tent_nova = (tent_q == TENT_W'(MAX_TENTATIVAS)) ? tent_q : tent_q + 1'b1;
      unique case (estado_q)
         OCIOSO: begin
            if (tecla_valida) begin
               if (tecla <= TECLA_MAX_DIGITO) begin
                  insere_d = 1'b1;
                  numero_d = tecla;
                  if (dig_q == DIG_W'(DIGITOS - 1)) begin
                     dig_d    = '0;
                     estado_d = ESPERA;
                     carga    = 1'b1;
                     // One extra cycle: the machine is still receiving the last digit.
                     valor    = TMR_W'(ESPERA_MAX + 1);
                  end else begin
                     dig_d = dig_q + 1'b1;
                  end
               end else if (tecla == TECLA_CANCELA) begin
                  dig_d = '0;
               end
            end
         end
         ESPERA: begin
            if (tmr_restante <= TMR_W'(ESPERA_MAX)) begin
               if (led_maquina) begin
                  aceito_d = 1'b1;
                  tent_d   = '0;
                  estado_d = LIBERADO;
                  carga    = 1'b1;
                  valor    = TMR_W'(ABERTO_CICLOS);
               end else if (tmr_expirou) begin
                  erro_d = 1'b1;
                  tent_d = tent_nova;
                  if (tent_nova == TENT_W'(MAX_TENTATIVAS)) begin
                     estado_d = BLOQUEIO;
                     carga    = 1'b1;
                     valor    = TMR_W'(BLOQUEIO_CICLOS);
                  end else begin
                     estado_d = OCIOSO;
                  end
               end
            end
         end
         LIBERADO: begin
            if (tmr_expirou) begin
               estado_d = OCIOSO;
            end
         end
         BLOQUEIO: begin
            if (tmr_expirou) begin
               tent_d   = '0;
               estado_d = OCIOSO;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q <= OCIOSO;
         dig_q    <= '0;
         tent_q   <= '0;
         insere_q <= 1'b0;
         numero_q <= '0;
         aceito_q <= 1'b0;
         erro_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         dig_q    <= dig_d;
         tent_q   <= tent_d;
         insere_q <= insere_d;
         numero_q <= numero_d;
         aceito_q <= aceito_d;
         erro_q   <= erro_d;
      end
   end

   assign insere     = insere_q;
   assign numero     = numero_q;
   assign aceito     = aceito_q;
   assign erro       = erro_q;
   assign tentativas = tent_q;
   assign aberto     = (estado_q == LIBERADO);
   assign bloqueado  = (estado_q == BLOQUEIO);

endmodule

// File: tb/tb_controle_tentativas.sv
// tb/tb_controle_tentativas.sv - scoreboard bench: cycle-stamped expectations from a transaction model
module tb_controle_tentativas;

   localparam int DIG   = 4;
   localparam int MAXT  = 3;
   localparam int ESP   = 8;
   localparam int ABR   = 20;
   localparam int BLQ   = 50;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tecla_valida = 1'b0;
   logic [4:1] tecla = '0;
   logic       led_maquina = 1'b0;
   logic       insere;
   logic [4:1] numero;
   logic       aberto;
   logic       bloqueado;
   logic       aceito;
   logic       erro;
   logic [1:0] tentativas;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   ev_t q_ins[$];
   ev_t q_res[$];
   ev_t q_ab[$];
   ev_t q_bl[$];

   int m_tent = 0;
   int m_dig = 0;
   int m_livre = 0;
   bit m_esp = 1'b0;
   int m_ult = 0;

   controle_tentativas #(
      .DIGITOS(DIG), .MAX_TENTATIVAS(MAXT), .ESPERA_MAX(ESP),
      .ABERTO_CICLOS(ABR), .BLOQUEIO_CICLOS(BLQ)
   ) dut (
      .clk(clk), .reset(reset), .tecla_valida(tecla_valida), .tecla(tecla),
      .led_maquina(led_maquina), .insere(insere), .numero(numero), .aberto(aberto),
      .bloqueado(bloqueado), .aceito(aceito), .erro(erro), .tentativas(tentativas)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nome, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: obtido %0d, esperado %0d (ciclo %0d)", nome, act, exp, cyc);
      end
   endfunction

   // Attempt-level model: keys are accepted only while idle; each finished code opens a
   // sampling window [last+2, last+1+ESP]; outcomes are stamped with the cycle they must appear.
   task automatic modelo(input int c, input logic v, input logic [3:0] t, input logic l);
      if (m_esp) begin
         if (l && c >= m_ult + 2) begin
            m_tent = 0;
            q_res.push_back('{c + 1, 16});
            q_ab.push_back('{c + 1, 1});
            q_ab.push_back('{c + 1 + ABR, 0});
            m_livre = c + 1 + ABR;
            m_esp = 1'b0;
         end else if (c == m_ult + 1 + ESP) begin
            m_tent = (m_tent < MAXT) ? m_tent + 1 : MAXT;
            q_res.push_back('{c + 1, 32 + m_tent});
            m_esp = 1'b0;
            m_livre = c + 1;
            if (m_tent == MAXT) begin
               q_bl.push_back('{c + 1, 1});
               q_bl.push_back('{c + 1 + BLQ, 0});
               m_livre = c + 1 + BLQ;
               m_tent = 0;
            end
         end
      end else if (c >= m_livre && v) begin
         if (t <= 4'd9) begin
            q_ins.push_back('{c + 1, int'(t)});
            m_dig++;
            if (m_dig == DIG) begin
               m_dig = 0;
               m_esp = 1'b1;
               m_ult = c;
            end
         end else if (t == 4'hF) begin
            m_dig = 0;
         end
      end
   endtask

   task automatic ciclo(input logic v, input logic [3:0] t, input logic l);
      @(posedge clk);
      #1;
      tecla_valida = v;
      tecla = t;
      led_maquina = l;
      modelo(cyc, v, t, l);
   endtask

   task automatic esvazia();
      for (int i = 0; i < 200 && (m_esp || cyc + 1 < m_livre); i++) ciclo(1'b0, 4'd0, 1'b0);
      ciclo(1'b0, 4'd0, 1'b0);
      ciclo(1'b0, 4'd0, 1'b0);
   endtask

   task automatic codigo(input int a, input int b, input int c, input int d);
      ciclo(1'b1, 4'(a), 1'b0);
      ciclo(1'b1, 4'(b), 1'b0);
      ciclo(1'b1, 4'(c), 1'b0);
      ciclo(1'b1, 4'(d), 1'b0);
   endtask

   ev_t e;
   logic ab_ant = 1'b0;
   logic bl_ant = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         ab_ant <= 1'b0;
         bl_ant <= 1'b0;
      end else begin
         if (insere) begin
            chk("insere_previsto", int'(q_ins.size() != 0), 1);
            if (q_ins.size() != 0) begin
               e = q_ins.pop_front();
               chk("insere_ciclo", cyc, e.cyc);
               chk("numero", int'(numero), e.val);
            end
         end
         if (aceito || erro) begin
            chk("resultado_previsto", int'(q_res.size() != 0), 1);
            if (q_res.size() != 0) begin
               e = q_res.pop_front();
               chk("resultado_ciclo", cyc, e.cyc);
               chk("resultado_tipo_tent", 16 * int'(aceito) + 32 * int'(erro) + int'(tentativas), e.val);
            end
         end
         if (aberto !== ab_ant) begin
            chk("aberto_borda_prevista", int'(q_ab.size() != 0), 1);
            if (q_ab.size() != 0) begin
               e = q_ab.pop_front();
               chk("aberto_borda", 2 * cyc + int'(aberto), 2 * e.cyc + e.val);
            end
         end
         if (bloqueado !== bl_ant) begin
            chk("bloqueado_borda_prevista", int'(q_bl.size() != 0), 1);
            if (q_bl.size() != 0) begin
               e = q_bl.pop_front();
               chk("bloqueado_borda", 2 * cyc + int'(bloqueado), 2 * e.cyc + e.val);
            end
         end
         if (q_ins.size() != 0 && q_ins[0].cyc < cyc) begin
            chk("insere_ausente", cyc, q_ins[0].cyc);
            void'(q_ins.pop_front());
         end
         if (q_res.size() != 0 && q_res[0].cyc < cyc) begin
            chk("resultado_ausente", cyc, q_res[0].cyc);
            void'(q_res.pop_front());
         end
         if (q_ab.size() != 0 && q_ab[0].cyc < cyc) begin
            chk("aberto_ausente", cyc, q_ab[0].cyc);
            void'(q_ab.pop_front());
         end
         if (q_bl.size() != 0 && q_bl[0].cyc < cyc) begin
            chk("bloqueado_ausente", cyc, q_bl[0].cyc);
            void'(q_bl.pop_front());
         end
         ab_ant <= aberto;
         bl_ant <= bloqueado;
      end
   end

   initial begin
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("reset_saidas", int'({insere, numero, aberto, bloqueado, aceito, erro, tentativas}), 0);

      ciclo(1'b1, 4'd5, 1'b0);
      ciclo(1'b1, 4'hF, 1'b0);
      ciclo(1'b0, 4'd0, 1'b0);

      codigo(1, 2, 3, 4);
      ciclo(1'b0, 4'd0, 1'b0);
      ciclo(1'b0, 4'd0, 1'b1);
      esvazia();
      chk("tent_apos_aceito", int'(tentativas), m_tent);

      for (int k = 0; k < 3; k++) begin
         codigo(9, 0, 9, 0);
         for (int i = 0; i < 10; i++) ciclo(1'b0, 4'd0, 1'b0);
      end
      ciclo(1'b1, 4'd6, 1'b0);
      esvazia();
      chk("tent_apos_bloqueio", int'(tentativas), m_tent);

      ciclo(1'b1, 4'd7, 1'b0);
      ciclo(1'b1, 4'd8, 1'b0);
      ciclo(1'b1, 4'hF, 1'b0);
      codigo(1, 2, 3, 4);
      esvazia();

      ciclo(1'b1, 4'd12, 1'b0);
      ciclo(1'b1, 4'd14, 1'b0);
      codigo(3, 1, 4, 1);
      ciclo(1'b0, 4'd0, 1'b1);
      ciclo(1'b0, 4'd0, 1'b1);
      esvazia();

      for (int i = 0; i < 3000; i++) begin
         ciclo(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0));
      end
      esvazia();

      codigo(5, 5, 5, 5);
      esvazia();
      codigo(2, 4, 6, 8);
      ciclo(1'b0, 4'd0, 1'b0);
      ciclo(1'b0, 4'd0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("reset_em_espera", int'({insere, numero, aberto, bloqueado, aceito, erro, tentativas}), 0);
      q_ins.delete();
      q_res.delete();
      q_ab.delete();
      q_bl.delete();
      m_tent = 0;
      m_dig = 0;
      m_esp = 1'b0;
      m_livre = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("tent_pos_reset", int'(tentativas), m_tent);
      ciclo(1'b1, 4'd5, 1'b0);
      ciclo(1'b0, 4'd0, 1'b0);
      esvazia();

      chk("fila_insere_vazia", q_ins.size(), 0);
      chk("fila_resultado_vazia", q_res.size(), 0);
      chk("fila_aberto_vazia", q_ab.size(), 0);
      chk("fila_bloqueado_vazia", q_bl.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
